// File: rtl/nubus_mem_arbiter.sv
// nubus_mem_arbiter
//   Shares one valid/strobe/ready memory port between requester A (NuBus slave path)
//   and requester B (local/host path). One owner is granted per access. The owner's
//   request is muxed onto the memory port, and ready/rdata are routed back to it. One
//   release cycle follows every access so the memory wait-state chain can clear.
//
// Parameters
//   PRIO_FIXED      0: round-robin on contention, 1: port A always wins contention
//   TIMEOUT_CLOCKS  grant cycles without m_ready_i before forced termination
//
// Ports
//   mem_clk, mem_reset        clock (posedge) and asynchronous active-high reset
//   a_*/b_*                   requester ports: valid held until ready, write = byte
//                             strobes (0 = read), addr, wdata in; rdata, ready out
//   m_*                       memory port: valid/write/addr/wdata out, rdata/ready in
//   arb_owner_o               0 = A, 1 = B (meaningful while arb_busy_o)
//   arb_busy_o                arbiter is in the grant state
//   a_err_o/b_err_o           only with NUBUS_MEM_ARB_TIMEOUT_EN: one-cycle pulse with the
//                             forced ready of a timed-out access
//
// Configuration
//   `define NUBUS_MEM_ARB_TIMEOUT_EN adds the grant timeout counter and the err ports.
module nubus_mem_arbiter #(
  parameter int unsigned PRIO_FIXED     = 0,
  parameter int unsigned TIMEOUT_CLOCKS = 15
) (
  input  logic        mem_clk,
  input  logic        mem_reset,

  input  logic        a_valid_i,
  input  logic [3:0]  a_write_i,
  input  logic [31:0] a_addr_i,
  input  logic [31:0] a_wdata_i,
  output logic [31:0] a_rdata_o,
  output logic        a_ready_o,

  input  logic        b_valid_i,
  input  logic [3:0]  b_write_i,
  input  logic [31:0] b_addr_i,
  input  logic [31:0] b_wdata_i,
  output logic [31:0] b_rdata_o,
  output logic        b_ready_o,

`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
  output logic        a_err_o,
  output logic        b_err_o,
`endif

  output logic        m_valid_o,
  output logic [3:0]  m_write_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic [31:0] m_rdata_i,
  input  logic        m_ready_i,

  output logic        arb_owner_o,
  output logic        arb_busy_o
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;

  logic        own_valid;
  logic [3:0]  own_write;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic        grant;
  logic        done;
  logic        term;
  logic [31:0] term_rdata;

`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CLOCKS + 1) > 4) ? $clog2(TIMEOUT_CLOCKS + 1) : 4;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CLOCKS;
`endif

  assign own_valid = owner_q ? b_valid_i : a_valid_i;
  assign own_write = owner_q ? b_write_i : a_write_i;
  assign own_addr  = owner_q ? b_addr_i  : a_addr_i;
  assign own_wdata = owner_q ? b_wdata_i : a_wdata_i;
  assign grant     = (state_q == StGrant);

  // Memory port and response routing are combinational from the registered owner.
  always_comb begin
    m_valid_o = grant & own_valid;
    m_write_o = grant ? own_write : 4'b0000;
    m_addr_o  = grant ? own_addr  : 32'h0;
    m_wdata_o = grant ? own_wdata : 32'h0;
    done      = m_valid_o & m_ready_i;
`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
    // A real acknowledge in the limit cycle takes precedence over the timeout.
    tmo        = m_valid_o & ~m_ready_i & (cnt_q == CntW'(TIMEOUT_CLOCKS - 1));
    term       = done | tmo;
    term_rdata = tmo ? 32'hFFFF_FFFF : m_rdata_i;
    a_err_o    = tmo & ~owner_q;
    b_err_o    = tmo & owner_q;
`else
    term       = done;
    term_rdata = m_rdata_i;
`endif
    a_ready_o = term & ~owner_q;
    b_ready_o = term & owner_q;
    a_rdata_o = (grant & ~owner_q) ? term_rdata : 32'h0;
    b_rdata_o = (grant & owner_q)  ? term_rdata : 32'h0;
  end

  assign arb_busy_o  = grant;
  assign arb_owner_o = owner_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (a_valid_i | b_valid_i) begin
          state_d = StGrant;
          if (a_valid_i & b_valid_i) begin
            owner_d = (PRIO_FIXED != 0) ? 1'b0 : ~last_q;
          end else begin
            owner_d = b_valid_i;
          end
`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      StGrant: begin
        if (!own_valid) begin
          // Abort: the owner withdrew before completion, fairness history kept.
          state_d = StRelease;
        end else if (term) begin
          state_d = StRelease;
          last_d  = owner_q;
        end else begin
`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Self-checking bench for nubus_mem_arbiter: a behavioural memory with random wait
// states, requester tasks that queue expected accesses, and a negedge monitor that
// scores every completion against a reference memory and the protocol rules.
module tb_nubus_mem_arbiter;

  localparam int unsigned PrioFixed = 0;
  localparam int unsigned TmoClocks = 15;

  logic        mem_clk = 1'b0;
  logic        mem_reset;
  logic        a_valid_i, b_valid_i;
  logic [3:0]  a_write_i, b_write_i;
  logic [31:0] a_addr_i, b_addr_i, a_wdata_i, b_wdata_i;
  logic [31:0] a_rdata_o, b_rdata_o;
  logic        a_ready_o, b_ready_o;
`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
  logic        a_err_o, b_err_o;
`endif
  logic        m_valid_o;
  logic [3:0]  m_write_o;
  logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
  logic        m_ready_i;
  logic        arb_owner_o, arb_busy_o;

  always #5 mem_clk = ~mem_clk;

  nubus_mem_arbiter #(
    .PRIO_FIXED    (PrioFixed),
    .TIMEOUT_CLOCKS(TmoClocks)
  ) dut (
    .mem_clk    (mem_clk),
    .mem_reset  (mem_reset),
    .a_valid_i  (a_valid_i),
    .a_write_i  (a_write_i),
    .a_addr_i   (a_addr_i),
    .a_wdata_i  (a_wdata_i),
    .a_rdata_o  (a_rdata_o),
    .a_ready_o  (a_ready_o),
    .b_valid_i  (b_valid_i),
    .b_write_i  (b_write_i),
    .b_addr_i   (b_addr_i),
    .b_wdata_i  (b_wdata_i),
    .b_rdata_o  (b_rdata_o),
    .b_ready_o  (b_ready_o),
`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
    .a_err_o    (a_err_o),
    .b_err_o    (b_err_o),
`endif
    .m_valid_o  (m_valid_o),
    .m_write_o  (m_write_o),
    .m_addr_o   (m_addr_o),
    .m_wdata_o  (m_wdata_o),
    .m_rdata_i  (m_rdata_i),
    .m_ready_i  (m_ready_i),
    .arb_owner_o(arb_owner_o),
    .arb_busy_o (arb_busy_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // ---------------- behavioural memory ----------------
  logic [31:0] dev_mem [64];
  logic [31:0] ref_mem [64];
  int          wait_cnt, wait_tgt;
  int          force_wait = -1;

  function automatic int next_wait();
    return (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
  endfunction

  assign m_ready_i = m_valid_o && (wait_cnt >= wait_tgt);
  assign m_rdata_i = dev_mem[m_addr_o[7:2]];

  always @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      wait_cnt <= 0;
      wait_tgt <= 0;
    end else if (m_valid_o && m_ready_i) begin
      if (m_write_o != 4'b0000)
        dev_mem[m_addr_o[7:2]] <= merge(dev_mem[m_addr_o[7:2]], m_wdata_o, m_write_o);
      wait_cnt <= 0;
      wait_tgt <= next_wait();
    end else if (m_valid_o) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
      wait_tgt <= next_wait();
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } req_t;

  req_t exp_a[$];
  req_t exp_b[$];
  int   order_q[$];

  task automatic handle(input bit p);
    req_t        e;
    logic [31:0] rd;
    if ((p ? exp_b.size() : exp_a.size()) == 0) begin
      check(p ? "spurious_b_ready" : "spurious_a_ready", p ? b_ready_o : a_ready_o, 0);
      return;
    end
    e  = p ? exp_b.pop_front() : exp_a.pop_front();
    rd = p ? b_rdata_o : a_rdata_o;
    order_q.push_back(int'(p));
`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
    if (p ? b_err_o : a_err_o) begin
      check("timeout_rdata", rd, 32'hFFFF_FFFF);
      return;
    end
`endif
    check("m_addr", m_addr_o, e.addr);
    check("m_write", {28'h0, m_write_o}, {28'h0, e.strb});
    if (e.strb == 4'b0000) begin
      check(p ? "b_rdata" : "a_rdata", rd, ref_mem[e.addr[7:2]]);
    end else begin
      check("m_wdata", m_wdata_o, e.data);
      ref_mem[e.addr[7:2]] = merge(ref_mem[e.addr[7:2]], e.data, e.strb);
    end
  endtask

  initial begin
    bit prev_rdy;
    prev_rdy = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (mem_reset) begin
        prev_rdy = 1'b0;
      end else begin
        if (prev_rdy) begin
          check("release_m_valid", m_valid_o, 0);
          check("release_ready", {30'h0, a_ready_o, b_ready_o}, 0);
        end
        if (a_ready_o && b_ready_o) check("dual_ready", {31'h0, b_ready_o}, 0);
        if (a_ready_o) handle(1'b0);
        if (b_ready_o) handle(1'b1);
        prev_rdy = a_ready_o | b_ready_o;
      end
    end
  end

  // ---------------- requesters ----------------
  task automatic drive(input bit p, input logic v, input logic [3:0] s,
                       input logic [31:0] ad, input logic [31:0] d);
    if (p) begin
      b_valid_i = v; b_write_i = s; b_addr_i = ad; b_wdata_i = d;
    end else begin
      a_valid_i = v; a_write_i = s; a_addr_i = ad; a_wdata_i = d;
    end
  endtask

  // Issues one access, holds it until ready and returns #1 after the completing edge.
  task automatic req(input bit p, input logic [3:0] s, input logic [31:0] ad,
                     input logic [31:0] d, output logic [31:0] rd);
    req_t e;
    e.addr = ad; e.data = d; e.strb = s;
    if (p) exp_b.push_back(e); else exp_a.push_back(e);
    drive(p, 1'b1, s, ad, d);
    rd = 32'h0;
    for (int i = 0; i < 200; i++) begin
      @(negedge mem_clk);
      if (p ? b_ready_o : a_ready_o) break;
    end
    rd = p ? b_rdata_o : a_rdata_o;
    if (!(p ? b_ready_o : a_ready_o))
      check(p ? "b_ready_wait" : "a_ready_wait", p ? b_ready_o : a_ready_o, 1);
    @(posedge mem_clk);
    #1;
  endtask

  task automatic pulse_reset();
    mem_reset = 1'b1;
    @(posedge mem_clk);
    #1;
    mem_reset = 1'b0;
  endtask

  // Expected service order when both ports keep na/nb accesses pending from reset.
  task automatic model_order(input int na, input int nb, output int ord[$]);
    bit last, w;
    last = 1'b1;
    ord.delete();
    while (na > 0 || nb > 0) begin
      if (na > 0 && nb > 0) w = (PrioFixed != 0) ? 1'b0 : !last;
      else                  w = (nb > 0);
      ord.push_back(int'(w));
      if (w) nb--; else na--;
      last = w;
    end
  endtask

  int          exp_ord[$];
  logic [31:0] rdv, tmp;
  int          cyc;

  initial begin
    for (int i = 0; i < 64; i++) begin
      dev_mem[i] = mem_init(32'(i * 4));
      ref_mem[i] = mem_init(32'(i * 4));
    end
    mem_reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge mem_clk);
    #1;
    check("rst_m_valid", m_valid_o, 0);
    check("rst_m_write", {28'h0, m_write_o}, 0);
    check("rst_m_addr", m_addr_o, 0);
    check("rst_m_wdata", m_wdata_o, 0);
    check("rst_ready", {30'h0, a_ready_o, b_ready_o}, 0);
    check("rst_a_rdata", a_rdata_o, 0);
    check("rst_b_rdata", b_rdata_o, 0);
    check("rst_busy_owner", {30'h0, arb_busy_o, arb_owner_o}, 0);
`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
    check("rst_err", {30'h0, a_err_o, b_err_o}, 0);
`endif
    mem_reset = 1'b0;

    // Zero-wait read: memory sees valid the cycle after the request, ready same cycle.
    force_wait = 0;
    @(posedge mem_clk);
    #1;
    begin
      req_t e;
      e.addr = 32'h10; e.data = 32'h0; e.strb = 4'h0;
      exp_a.push_back(e);
    end
    drive(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
    @(negedge mem_clk);
    check("t1_idle_m_valid", m_valid_o, 0);
    @(negedge mem_clk);
    check("t1_m_valid", m_valid_o, 1);
    check("t1_a_ready", a_ready_o, 1);
    check("t1_a_rdata", a_rdata_o, mem_init(32'h10));
    @(posedge mem_clk);
    #1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge mem_clk);
    check("t1_release_busy", arb_busy_o, 0);

    // Both ports held continuously for 4 accesses each.
    pulse_reset();
    force_wait = -1;
    order_q.delete();
    fork
      begin
        logic [31:0] d0;
        for (int i = 0; i < 4; i++) req(1'b0, 4'h0, 32'(i * 4), 32'h0, d0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
      begin
        logic [31:0] d1;
        for (int i = 0; i < 4; i++) req(1'b1, 4'h0, 32'(128 + i * 4), 32'h0, d1);
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      end
    join
    model_order(4, 4, exp_ord);
    check("order_len", order_q.size(), exp_ord.size());
    for (int i = 0; i < 8; i++)
      if (i < order_q.size()) check($sformatf("order_%0d", i), order_q[i], exp_ord[i]);

    // Partial-strobe write with wait states, then readback.
    force_wait = 3;
    repeat (2) @(posedge mem_clk);
    #1;
    req(1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF, rdv);
    req(1'b1, 4'b0000, 32'h40, 32'h0, rdv);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    tmp = mem_init(32'h40);
    check("t4_readback", rdv, {tmp[31:16], 16'hBEEF});

    // Abort: A withdraws after one grant cycle, arbitration history stays at reset.
    pulse_reset();
    drive(1'b0, 1'b1, 4'h0, 32'h20, 32'h0);
    @(posedge mem_clk);
    #1;
    @(negedge mem_clk);
    check("t5_grant_busy", arb_busy_o, 1);
    check("t5_no_ready", a_ready_o, 0);
    @(posedge mem_clk);
    #1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge mem_clk);
    check("t5_abort_m_valid", m_valid_o, 0);
    check("t5_abort_ready", a_ready_o, 0);
    @(negedge mem_clk);
    check("t5_release_busy", arb_busy_o, 0);
    @(posedge mem_clk);
    #1;
    order_q.delete();
    fork
      begin
        logic [31:0] d2;
        req(1'b0, 4'h0, 32'h24, 32'h0, d2);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
      begin
        logic [31:0] d3;
        req(1'b1, 4'h0, 32'h28, 32'h0, d3);
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      end
    join
    model_order(1, 1, exp_ord);
    if (order_q.size() > 0) check("t5_tie_winner", order_q[0], exp_ord[0]);
    else check("t5_tie_len", order_q.size(), 2);

    // Reset in the middle of a B grant.
    force_wait = 10;
    @(posedge mem_clk);
    #1;
    drive(1'b1, 1'b1, 4'h0, 32'h30, 32'h0);
    @(posedge mem_clk);
    #1;
    @(negedge mem_clk);
    check("t6_owner_b", arb_owner_o, 1);
    check("t6_m_valid", m_valid_o, 1);
    @(posedge mem_clk);
    #2;
    mem_reset = 1'b1;
    #1;
    check("t6_rst_m_valid", m_valid_o, 0);
    check("t6_rst_m_addr", m_addr_o, 0);
    check("t6_rst_busy_owner", {30'h0, arb_busy_o, arb_owner_o}, 0);
    check("t6_rst_ready", {30'h0, a_ready_o, b_ready_o}, 0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge mem_clk);
    #1;
    mem_reset = 1'b0;

`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
    // Memory never acknowledges: forced completion in the TIMEOUT_CLOCKS-th grant cycle.
    force_wait = 1000;
    @(posedge mem_clk);
    #1;
    begin
      req_t e;
      e.addr = 32'h14; e.data = 32'h0; e.strb = 4'h0;
      exp_a.push_back(e);
    end
    drive(1'b0, 1'b1, 4'h0, 32'h14, 32'h0);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge mem_clk);
      if (arb_busy_o) cyc++;
      if (a_ready_o) break;
    end
    check("tmo_cycle", cyc, TmoClocks);
    check("tmo_err", a_err_o, 1);
    @(posedge mem_clk);
    #1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge mem_clk);
    check("tmo_err_pulse", a_err_o, 0);
`endif

    // Randomized traffic from both ports.
    force_wait = -1;
    fork
      begin
        logic [31:0] d4;
        logic [3:0]  s4;
        for (int i = 0; i < 30; i++) begin
          s4 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          req(1'b0, s4, 32'($urandom_range(0, 63)) << 2, $urandom, d4);
          if ($urandom_range(0, 2) == 0) begin
            drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            repeat ($urandom_range(1, 4)) @(posedge mem_clk);
            #1;
          end
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
      begin
        logic [31:0] d5;
        logic [3:0]  s5;
        for (int i = 0; i < 30; i++) begin
          s5 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          req(1'b1, s5, 32'($urandom_range(0, 63)) << 2, $urandom, d5);
          if ($urandom_range(0, 2) == 0) begin
            drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
            repeat ($urandom_range(1, 4)) @(posedge mem_clk);
            #1;
          end
        end
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      end
    join
    repeat (5) @(posedge mem_clk);
    #1;
    check("exp_a_drained", exp_a.size(), 0);
    check("exp_b_drained", exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
